// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-client sequencer for the shared word memory
module mem_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_done,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_err,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_done,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_err,
    output logic              mem_rd_enable,
    output logic              mem_wr_enable,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_busy,
    input  logic              mem_rd_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] TO = 4'(TIMEOUT);

    state_t            state;
    logic              ptr;
    logic              sel;
    logic              we;
    logic [3:0]        cnt;
    logic [1:0]        done;
    logic [1:0]        err;
    logic              gnt;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    assign c0_done = done[0];
    assign c1_done = done[1];
    assign c0_err  = err[0];
    assign c1_err  = err[1];

    // pick the client to grant: the pointer breaks ties, otherwise the lone requester wins
    always_comb begin
        gnt     = (c0_req && c1_req) ? ptr : c1_req;
        g_we    = gnt ? c1_we : c0_we;
        g_addr  = gnt ? c1_addr : c0_addr;
        g_wdata = gnt ? c1_wdata : c0_wdata;
    end

    // transaction sequencer; enables are set on the grant edge so they are high only during ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            sel           <= 1'b0;
            we            <= 1'b0;
            cnt           <= '0;
            done          <= '0;
            err           <= '0;
            c0_rdata      <= '0;
            c1_rdata      <= '0;
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            mem_rd_addr   <= '0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
        end else begin
            case (state)
                IDLE: if (!mem_busy && (c0_req || c1_req)) begin
                    sel           <= gnt;
                    we            <= g_we;
                    if (c0_req && c1_req) ptr <= !ptr;
                    mem_rd_enable <= !g_we;
                    mem_wr_enable <= g_we;
                    mem_rd_addr   <= g_addr;
                    mem_wr_addr   <= g_addr;
                    mem_wr_data   <= g_wdata;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    mem_rd_enable <= 1'b0;
                    mem_wr_enable <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: if (we ? !mem_busy : mem_rd_ready) begin
                    done[sel] <= 1'b1;
                    if (!we && sel) c1_rdata <= mem_rd_data;
                    if (!we && !sel) c0_rdata <= mem_rd_data;
                    state     <= DONE;
                end else if (cnt == TO) begin
                    done[sel] <= 1'b1;
                    err[sel]  <= 1'b1;
                    if (sel) c1_rdata <= '0;
                    else c0_rdata <= '0;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                default: begin
                    done  <= '0;
                    err   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, latency, busy gating, timeout and reset
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [15:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
    logic        c0_done, c0_err, c1_done, c1_err;
    logic [15:0] c0_rdata, c1_rdata;
    logic        mem_rd_enable, mem_wr_enable, mem_busy, mem_rd_ready;
    logic [15:0] mem_rd_addr, mem_wr_addr, mem_wr_data, rd_q;

    logic        force_busy, no_ready, busy_m, ready_m, mrd, prev_en;
    logic [2:0]  mcnt;
    logic [7:0]  maddr;
    logic [15:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;
    int rd_pulses, wr_pulses, early, n;
    logic [15:0] en_addr, en_data;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_done(c0_done), .c0_rdata(c0_rdata), .c0_err(c0_err),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_done(c1_done), .c1_rdata(c1_rdata), .c1_err(c1_err),
        .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(rd_q), .mem_busy(mem_busy), .mem_rd_ready(mem_rd_ready)
    );

    assign mem_busy     = busy_m | force_busy;
    assign mem_rd_ready = ready_m & ~no_ready;

    // memory wrapper: busy for cycles k+2..k+6 after an enable in k+1, rd_ready pulse in k+7
    always @(posedge clk) begin
        if (rst) begin
            mcnt    <= 3'd0;
            busy_m  <= 1'b0;
            ready_m <= 1'b0;
            mrd     <= 1'b0;
            maddr   <= 8'd0;
            rd_q    <= 16'd0;
            mem[5]  <= 16'hBEEF;
        end else begin
            ready_m <= 1'b0;
            if (mem_rd_enable || mem_wr_enable) begin
                mcnt   <= 3'd5;
                busy_m <= 1'b1;
                mrd    <= mem_rd_enable;
                maddr  <= mem_rd_addr[7:0];
                if (mem_wr_enable) mem[mem_wr_addr[7:0]] <= mem_wr_data;
            end else if (mcnt == 3'd1) begin
                mcnt    <= 3'd0;
                busy_m  <= 1'b0;
                ready_m <= mrd;
                rd_q    <= mem[maddr];
            end else if (mcnt != 3'd0) begin
                mcnt <= mcnt - 3'd1;
            end
        end
    end

    // bus-wide invariants: exclusive single-cycle enables, never two done pulses at once
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            assert (!(mem_rd_enable && mem_wr_enable) && !(prev_en && (mem_rd_enable || mem_wr_enable)) && !(c0_done && c1_done))
            else begin
                n_fail++;
                $error("FAIL bus_excl: rd_en=%b wr_en=%b prev_en=%b done0=%b done1=%b, required exclusive single-cycle", mem_rd_enable, mem_wr_enable, prev_en, c0_done, c1_done);
            end
        end
        prev_en = mem_rd_enable || mem_wr_enable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
            if (mem_rd_enable) begin
                rd_pulses++;
                en_addr = mem_rd_addr;
            end
            if (mem_wr_enable) begin
                wr_pulses++;
                en_addr = mem_wr_addr;
                en_data = mem_wr_data;
            end
        end while (!(c0_done || c1_done) && cycles < 60);
    endtask

    task automatic idle();
        c0_req = 1'b0;
        c1_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
        force_busy = 0; no_ready = 0;
        rd_pulses = 0; wr_pulses = 0; en_addr = 0; en_data = 0;
        repeat (3) tick();
        chk("rst_rd_en", mem_rd_enable, 0);
        chk("rst_wr_en", mem_wr_enable, 0);
        chk("rst_addr", mem_rd_addr | mem_wr_addr, 0);
        chk("rst_wdata", mem_wr_data, 0);
        chk("rst_done", {c0_done, c1_done, c0_err, c1_err}, 0);
        chk("rst_rdata", c0_rdata | c1_rdata, 0);
        rst = 1'b0;
        tick();

        c0_req = 1; c0_we = 0; c0_addr = 16'h0005;
        wait_done(n);
        chk("rd_latency", n, 8);
        chk("rd_done0", c0_done, 1);
        chk("rd_done1", c1_done, 0);
        chk("rd_data", c0_rdata, 16'hBEEF);
        chk("rd_err", c0_err, 0);
        chk("rd_pulses", rd_pulses, 1);
        chk("rd_addr", en_addr, 16'h0005);
        chk("rd_no_wr", wr_pulses, 0);
        idle();

        rd_pulses = 0; wr_pulses = 0;
        c1_req = 1; c1_we = 1; c1_addr = 16'h0010; c1_wdata = 16'h1234;
        wait_done(n);
        chk("wr_latency", n, 8);
        chk("wr_done1", c1_done, 1);
        chk("wr_done0", c0_done, 0);
        chk("wr_pulses", wr_pulses, 1);
        chk("wr_no_rd", rd_pulses, 0);
        chk("wr_addr", en_addr, 16'h0010);
        chk("wr_data", en_data, 16'h1234);
        idle();
        c1_req = 1; c1_we = 0;
        wait_done(n);
        chk("rb_latency", n, 8);
        chk("rb_done1", c1_done, 1);
        chk("rb_data", c1_rdata, 16'h1234);
        chk("rb_err", c1_err, 0);
        idle();

        c0_req = 1; c0_we = 0; c0_addr = 16'h0005;
        c1_req = 1; c1_we = 0; c1_addr = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            wait_done(n);
            chk("cont_latency", n, (i == 0) ? 8 : 9);
            chk("cont_done0", c0_done, (i % 2) == 0);
            chk("cont_done1", c1_done, (i % 2) == 1);
            chk("cont_rdata", (i % 2) ? c1_rdata : c0_rdata, (i % 2) ? 16'h1234 : 16'hBEEF);
        end
        idle();

        force_busy = 1; early = 0;
        c0_req = 1; c0_we = 0; c0_addr = 16'h0005;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rd_enable || mem_wr_enable || c0_done) early++;
        end
        chk("busy_no_enable", early, 0);
        force_busy = 0;
        tick();
        chk("busy_grant_en", mem_rd_enable, 1);
        wait_done(n);
        chk("busy_latency", n, 7);
        chk("busy_data", c0_rdata, 16'hBEEF);
        idle();

        no_ready = 1;
        c0_req = 1; c0_we = 0; c0_addr = 16'h0005;
        wait_done(n);
        chk("to_latency", n, 18);
        chk("to_done0", c0_done, 1);
        chk("to_err", c0_err, 1);
        chk("to_rdata", c0_rdata, 0);
        chk("to_err1", c1_err, 0);
        no_ready = 0;
        idle();
        c1_req = 1; c1_we = 0; c1_addr = 16'h0010;
        wait_done(n);
        chk("post_to_latency", n, 8);
        chk("post_to_err", c1_err, 0);
        chk("post_to_data", c1_rdata, 16'h1234);
        idle();

        c0_req = 1; c0_we = 1; c0_addr = 16'h0020; c0_wdata = 16'h5555;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_en", {mem_rd_enable, mem_wr_enable}, 0);
        chk("mid_rst_addr", mem_rd_addr | mem_wr_addr, 0);
        chk("mid_rst_wdata", mem_wr_data, 0);
        chk("mid_rst_done", {c0_done, c1_done, c0_err, c1_err}, 0);
        chk("mid_rst_rdata", c0_rdata | c1_rdata, 0);
        rst = 1'b0; c0_req = 0; early = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (c0_done || mem_rd_enable || mem_wr_enable) early++;
        end
        chk("mid_rst_no_done", early, 0);
        c1_req = 1; c1_we = 0; c1_addr = 16'h0010;
        wait_done(n);
        chk("post_rst_latency", n, 8);
        chk("post_rst_done1", c1_done, 1);
        chk("post_rst_data", c1_rdata, 16'h1234);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-client arbiter and sequencer for the shared IMemory word buffer (`AlteraMemory` behind its busy/rd_ready wrapper). The MIL-1553 side (client 0) and the SPI side (client 1) each present one-word read or write requests. The block grants requests round-robin, issues exactly one single-cycle enable pulse to memory, and tracks memory busy/rd_ready. It then returns a done pulse, read data and an error flag to the granted client, and guarantees that the two clients never drive the memory at the same time.

## Interface
Parameters:
- ADDR_W, 16, address width carried to memory (memory decodes [7:0])
- DATA_W, 16, data word width
- TIMEOUT, 15, max cycles in WAIT before the transaction is aborted with error (4-bit counter, legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cN_req  in  1  client N (N=0,1) request; held high with cN_we/cN_addr/cN_wdata stable until cN_done
- cN_we  in  1  1 = write, 0 = read
- cN_addr  in  ADDR_W  word address
- cN_wdata  in  DATA_W  write data
- cN_done  out  1  one-cycle completion pulse
- cN_rdata  out  DATA_W  read data, valid while cN_done=1
- cN_err  out  1  timeout flag, valid while cN_done=1
- mem_rd_enable  out  1  memory read strobe
- mem_wr_enable  out  1  memory write strobe
- mem_rd_addr  out  ADDR_W  memory read address
- mem_wr_addr  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data
- mem_busy  in  1  memory busy
- mem_rd_ready  in  1  read data ready strobe

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - Proceeds only when mem_busy=0 and at least one request is asserted.
  - With one request asserted, that client is granted.
  - With both asserted, the client indicated by the priority pointer is granted; the pointer then moves to the other client.
  - Grant latches sel, we, addr and wdata; next state ISSUE.
- ISSUE (exactly one cycle):
  - mem_rd_enable=!we, mem_wr_enable=we.
  - mem_rd_addr=mem_wr_addr=addr, mem_wr_data=wdata.
  - WAIT counter cleared; next state WAIT.
- WAIT:
  - Both enables are 0; addresses and write data hold their values.
  - Read completes when mem_rd_ready=1: mem_rd_data is latched into rdata; next state DONE.
  - Write completes when mem_busy=0: next state DONE.
  - The counter increments each WAIT cycle. When the counter reaches TIMEOUT without completion: err=1, rdata=0; next state DONE.
- DONE (one cycle):
  - c[sel]_done=1, c[sel]_rdata, c[sel]_err driven.
  - The non-granted client's done stays 0.
  - Next state IDLE.
- Outputs of the non-granted client hold 0 (done/err) and hold their last value (rdata).
- A client that drops req mid-transaction does not abort it; the transaction completes and done still pulses.
- Back-to-back operation: a client sees done at the end of the DONE cycle and may present a new request the next cycle. IDLE samples that request, so no duplicate grant occurs.
- Reset:
  - state=IDLE, pointer=client 0.
  - All outputs 0: enables, addresses, wr_data, done, err, rdata.
  - Reset asserted mid-transaction drops the transaction; no done pulse is issued.

## Timing
- A request sampled in IDLE at edge k drives ISSUE during cycle k+1.
- With memory delays Read=6 and Write=5:
  - read: mem_rd_ready during k+7; done during k+8 (8-cycle latency).
  - write: mem_busy low during k+7; done during k+8.
- Throughput: one transaction per 9 cycles (DONE → IDLE → grant adds one cycle).
- Timeout: done occurs at ISSUE + TIMEOUT + 2 cycles.
- Memory enables are never high for more than one cycle, and never both high in the same cycle.

## Test plan
- Single read: c0 read addr 0x0005, memory holds 0xBEEF → mem_rd_enable one pulse with addr 0x0005; c0_done at k+8 with rdata=0xBEEF, err=0.
- Single write then read back: c1 writes 0x1234 to 0x0010, then reads 0x0010 → mem_wr_enable one pulse with data 0x1234; c1_done at k+8; readback returns 0x1234.
- Contention: c0 and c1 request in the same cycle, pointer=0 → c0 served first, then c1. Repeat with both held → services alternate 0,1,0,1; c1_done never coincides with c0_done.
- Busy gating: start with mem_busy forced high for 10 cycles after a request → no enable until busy drops; the grant happens the cycle after busy drops.
- Timeout: read with mem_rd_ready tied low → done at ISSUE+17 with err=1, rdata=0; the next request is served normally.
- Reset mid-op: assert rst during WAIT of a c0 write → all outputs 0 next cycle, no c0_done. After release, a new c1 request is granted first (pointer=0 and only c1 requesting).
